// File: rtl/prime_sweep_ctrl.sv
// Sweep sequencer for the single-number prime checker core: runs every value
// in [lo_i, hi_i] through the core and gathers a prime bitmap and count.
module prime_sweep_ctrl #(
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [W-1:0]      lo_i,
  input  logic [W-1:0]      hi_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2**W-1:0]   prime_map_o,
  output logic [W:0]        prime_cnt_o,
  output logic              chk_en_o,
  output logic [W-1:0]      chk_data_o,
  input  logic              chk_valid_i,
  input  logic              chk_prime_i
);

  localparam int unsigned CW = W + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  // FIN is entered on the cycle after this timer value, i.e. exactly
  // TIMEOUT cycles after the ISSUE cycle.
  localparam int unsigned TLAST = TIMEOUT - 2;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    NEXT,
    FIN
  } state_t;

  state_t        state;
  logic [W-1:0]  cur;
  logic [W-1:0]  hi_q;
  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      hi_q        <= '0;
      timer       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      prime_map_o <= '0;
      prime_cnt_o <= '0;
      chk_en_o    <= 1'b0;
      chk_data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            cur         <= lo_i;
            hi_q        <= hi_i;
            prime_map_o <= '0;
            prime_cnt_o <= '0;
            if (lo_i > hi_i) begin
              err_o  <= 1'b1;
              done_o <= 1'b1;
              state  <= FIN;
            end else begin
              err_o  <= 1'b0;
              busy_o <= 1'b1;
              state  <= CHECK;
            end
          end
        end

        // 0 and 1 are never sent to the core; they are simply not prime.
        CHECK: begin
          if (cur < W'(2)) begin
            state <= NEXT;
          end else begin
            chk_data_o <= cur;
            chk_en_o   <= 1'b1;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          chk_en_o <= 1'b0;
          timer    <= '0;
          state    <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (!chk_valid_i) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (timer == TW'(TLAST)) begin
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= FIN;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        WAIT_DONE: begin
          if (chk_valid_i) begin
            if (chk_prime_i) begin
              prime_map_o[cur] <= 1'b1;
              prime_cnt_o      <= prime_cnt_o + CW'(1);
            end
            state <= NEXT;
          end else if (timer == TW'(TLAST)) begin
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= FIN;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        // Equality stop so hi = all-ones terminates without wrapping cur.
        NEXT: begin
          if (cur == hi_q) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= FIN;
          end else begin
            cur   <= cur + W'(1);
            state <= CHECK;
          end
        end

        FIN: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_o   <= 1'b0;
          done_o   <= 1'b0;
          chk_en_o <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// Directed bench for prime_sweep_ctrl with a behavioural checker-core model
// and a stub mode that never leaves the valid state.
`timescale 1ns/1ps
module tb_prime_sweep_ctrl;

  localparam int W       = 4;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [W-1:0]    lo_i, hi_i;
  logic            busy_o, done_o, err_o;
  logic [2**W-1:0] prime_map_o;
  logic [W:0]      prime_cnt_o;
  logic            chk_en_o;
  logic [W-1:0]    chk_data_o;
  logic            chk_valid_i, chk_prime_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prime_sweep_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .lo_i(lo_i), .hi_i(hi_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .prime_map_o(prime_map_o), .prime_cnt_o(prime_cnt_o),
    .chk_en_o(chk_en_o), .chk_data_o(chk_data_o),
    .chk_valid_i(chk_valid_i), .chk_prime_i(chk_prime_i)
  );

  // Core model: valid drops two cycles after en, then trial division 2..n-1.
  logic         stub;
  logic         core_valid, core_prime;
  int           core_state, core_d;
  logic [W-1:0] core_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_valid <= 1'b1;
      core_prime <= 1'b0;
      core_state <= 0;
      core_d     <= 2;
      core_n     <= '0;
    end else begin
      case (core_state)
        0: if (chk_en_o && !stub) begin
             core_n     <= chk_data_o;
             core_state <= 1;
           end
        1: begin
             core_valid <= 1'b0;
             core_d     <= 2;
             core_state <= 2;
           end
        default: begin
          if (core_d >= int'(core_n)) begin
            core_prime <= 1'b1;
            core_valid <= 1'b1;
            core_state <= 0;
          end else if ((int'(core_n) % core_d) == 0) begin
            core_prime <= 1'b0;
            core_valid <= 1'b1;
            core_state <= 0;
          end else begin
            core_d <= core_d + 1;
          end
        end
      endcase
    end
  end

  assign chk_valid_i = stub ? 1'b1 : core_valid;
  assign chk_prime_i = stub ? 1'b0 : core_prime;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a sweep and follows it to done_o; optionally re-pulses start_i
  // at cycle poke to confirm it is ignored while busy.
  task automatic run_sweep(input logic [W-1:0] lo, input logic [W-1:0] hi, input int poke,
                           output int en_n, output int done_n,
                           output int cyc_issue, output int cyc_done);
    int cyc;
    @(negedge clk);
    lo_i = lo; hi_i = hi; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_accept", 32'(busy_o), 32'(lo <= hi));
    en_n = 0; done_n = 0; cyc = 0; cyc_issue = -1; cyc_done = -1;
    while (done_n == 0 && cyc < 2000) begin
      if (chk_en_o) begin
        en_n++;
        cyc_issue = cyc;
        if (chk_data_o < 4'd2) chk("core_operand_ge2", 32'(chk_data_o), 32'd2);
      end
      if (core_state != 0 && chk_data_o !== core_n)
        chk("chk_data_stable", 32'(chk_data_o), 32'(core_n));
      if (done_o) begin
        done_n++;
        cyc_done = cyc;
      end
      if (cyc == poke)     begin start_i = 1'b1; lo_i = '0; hi_i = '0; end
      if (cyc == poke + 1) start_i = 1'b0;
      if (done_n == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    start_i = 1'b0;
    chk("done_seen", 32'(done_n), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("busy_after_done", 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    logic [W-1:0]    lo;
    logic [W-1:0]    hi;
    logic [2**W-1:0] map;
    logic [W:0]      cnt;
    logic            err;
    int              en;
    int              poke;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int en_n, done_n, ci, cd;

    vecs[0] = '{lo: 4'd2,  hi: 4'd15, map: 16'h28AC, cnt: 5'd6, err: 1'b0, en: 14, poke: -10};
    vecs[1] = '{lo: 4'd0,  hi: 4'd1,  map: 16'h0000, cnt: 5'd0, err: 1'b0, en: 0,  poke: -10};
    vecs[2] = '{lo: 4'd9,  hi: 4'd4,  map: 16'h0000, cnt: 5'd0, err: 1'b1, en: 0,  poke: -10};
    vecs[3] = '{lo: 4'd7,  hi: 4'd7,  map: 16'h0080, cnt: 5'd1, err: 1'b0, en: 1,  poke: -10};
    vecs[4] = '{lo: 4'd15, hi: 4'd15, map: 16'h0000, cnt: 5'd0, err: 1'b0, en: 1,  poke: -10};
    vecs[5] = '{lo: 4'd2,  hi: 4'd15, map: 16'h28AC, cnt: 5'd6, err: 1'b0, en: 14, poke: 30};
    vecs[6] = '{lo: 4'd11, hi: 4'd13, map: 16'h2800, cnt: 5'd2, err: 1'b0, en: 3,  poke: -10};

    stub = 1'b0; start_i = 1'b0; lo_i = '0; hi_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_err",  32'(err_o),  32'd0);
    chk("reset_map",  32'(prime_map_o), 32'd0);
    chk("reset_cnt",  32'(prime_cnt_o), 32'd0);
    chk("reset_en",   32'(chk_en_o), 32'd0);
    chk("reset_data", 32'(chk_data_o), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_sweep(vecs[i].lo, vecs[i].hi, vecs[i].poke, en_n, done_n, ci, cd);
      chk($sformatf("v%0d_map", i), 32'(prime_map_o), 32'(vecs[i].map));
      chk($sformatf("v%0d_cnt", i), 32'(prime_cnt_o), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].err));
      chk($sformatf("v%0d_en_pulses", i), 32'(en_n), 32'(vecs[i].en));
      if (i == 1) chk("v1_latency_4to5", 32'((cd + 1) >= 4 && (cd + 1) <= 5), 32'd1);
    end
    chk("data_held_after_sweep", 32'(chk_data_o), 32'd13);

    // Core stuck in valid: abort TIMEOUT cycles after the ISSUE cycle.
    stub = 1'b1;
    run_sweep(4'd5, 4'd5, -10, en_n, done_n, ci, cd);
    chk("to_latency", 32'(cd - ci), 32'(TIMEOUT));
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_map", 32'(prime_map_o), 32'd0);
    chk("to_en_pulses", 32'(en_n), 32'd1);
    stub = 1'b0;

    // Asynchronous reset mid-sweep clears everything with no done pulse.
    @(negedge clk);
    lo_i = 4'd2; hi_i = 4'd15; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {busy_o, done_o, err_o, chk_en_o, chk_data_o, prime_cnt_o}, 32'd0);
    chk("mid_rst_map", 32'(prime_map_o), 32'd0);
    done_n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_o) done_n++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done_o) done_n++;
    end
    chk("mid_rst_no_done", 32'(done_n), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
